adder_tree_accumulator: RTL and testbench
=========================================

ADDER_TREE_ACCUMULATOR -- requirements
Module: adder_tree_accumulator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 5: width of each signed two's-complement addend.
REQ-002 SHALL have parameter LENGTH, default 9: addends per beat; legal range 2..64.
REQ-003 SHALL have parameter ACC_EXTRA, default 2: extra accumulator bits; OUT_WIDTH = DATA_WIDTH + $clog2(LENGTH) + ACC_EXTRA; TREE_DEPTH = $clog2(LENGTH).
REQ-004 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, 1: input beat present.
REQ-007 SHALL have port in_ready, output, 1: block accepts a beat this cycle.
REQ-008 SHALL have port in_addends, input, DATA_WIDTH x LENGTH (unpacked array): signed addends.
REQ-009 SHALL have port in_mode, input, 1: 0 = per-beat sum, 1 = accumulate across beats.
REQ-010 SHALL have port in_last, input, 1: final beat of an accumulate packet; ignored when in_mode=0.
REQ-011 SHALL have port out_valid, output, 1: result present.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts result.
REQ-013 SHALL have port out_sum, output, OUT_WIDTH: signed result.
REQ-014 SHALL have port out_overflow, output, 1: result wrapped outside signed OUT_WIDTH range.

Function
REQ-015 Beat accepted when in_valid && in_ready; in_addends, in_mode, in_last captured on that edge.
REQ-016 Global advance = !out_valid || out_ready; in_ready SHALL equal advance (combinational, no dependence on in_valid).
REQ-017 Tree SHALL have TREE_DEPTH registered stages, each summing adjacent pairs, with odd leftover element passed through unchanged; each stage widens by 1 bit with sign extension.
REQ-018 Each tree stage SHALL carry a valid bit, mode and last alongside data; all stages advance together only when advance=1, else hold.
REQ-019 When advance=1 and no beat accepted, a bubble (valid=0) SHALL enter stage 0; bubbles SHALL not modify the accumulator or produce output.
REQ-020 Final stage SHALL feed an output/accumulate stage; with no stalls, out_valid for a mode-0 beat SHALL rise exactly TREE_DEPTH+1 cycles after acceptance (5 for LENGTH=9).
REQ-021 Mode 0: out_sum = sign-extended tree sum; out_overflow = 0; accumulator untouched.
REQ-022 Mode 1, last=0: acc <= acc + tree sum (wrapping, OUT_WIDTH bits); no output produced; sticky ovf flag SHALL set if signed addition overflows.
REQ-023 Mode 1, last=1: out_sum = acc + tree sum; out_overflow = ovf OR overflow of this addition; acc and ovf cleared to 0 in the same edge.
REQ-024 out_sum and out_overflow SHALL hold stable while out_valid=1 && out_ready=0.
REQ-025 Mode-0 beats interleaved inside an open accumulate packet SHALL output independently and leave acc/ovf unchanged.
REQ-026 Full throughput: with out_ready=1 continuously, one beat accepted per cycle, one result per mode-0 or last beat.
REQ-027 Output and new result on same edge: when out_valid && out_ready and a new result arrives, out_valid stays 1 with new data; otherwise it drops.

Reset
REQ-028 On reset low, asynchronously: all stage valids 0, out_valid 0, out_sum 0, out_overflow 0, acc 0, ovf 0; in_ready SHALL read 1 during and after reset.
REQ-029 Reset asserted mid-packet SHALL discard partial accumulation and all in-flight beats; no output produced for them after release.
REQ-030 Tree data registers need no reset value; X on in_addends while in_valid=0 SHALL not propagate to out_sum or acc.

Verification
REQ-031 LENGTH=9, DATA_WIDTH=5, mode 0, addends {1,-2,3,-4,5,-6,7,-8,9}, out_ready=1 -> out_valid exactly 5 cycles later, out_sum=5, out_overflow=0; X inputs afterwards leave no further output.
REQ-032 Mode 1, same vector on three consecutive beats, last on third -> single output out_sum=15, no output for beats 1-2, acc cleared after.
REQ-033 out_ready held 0 for 4 cycles with result pending -> in_ready=0, out_sum stable at 5, pipeline holds; release -> remaining beats emerge in order, none lost or duplicated.
REQ-034 ACC_EXTRA=0 (OUT_WIDTH=9), mode 1, two beats of all 15s (135 each), last on second -> out_sum=-242 (wrapped 270), out_overflow=1; next packet of one beat all 1s -> out_sum=9, out_overflow=0.
REQ-035 Mode 1 beat (all 1s), then reset pulse, then mode 1 last beat all 2s -> out_sum=18 only.
REQ-036 Mode-0 beat (sum 5) inserted between mode-1 beats of 9 and last 9 -> outputs 5 then 18, in that order.

Source files
------------

// File: rtl/adder_tree_accumulator.sv
// Pipelined signed adder tree with an optional cross-beat accumulator on its output.
// One beat per cycle; a single advance signal stalls every stage together.
module adder_tree_accumulator #(
  parameter int unsigned DATA_WIDTH = 5,
  parameter int unsigned LENGTH     = 9,
  parameter int unsigned ACC_EXTRA  = 2,
  localparam int unsigned TREE_DEPTH = $clog2(LENGTH),
  localparam int unsigned SUM_WIDTH  = DATA_WIDTH + TREE_DEPTH,
  localparam int unsigned OUT_WIDTH  = SUM_WIDTH + ACC_EXTRA
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_addends [LENGTH],
  input  logic                         in_mode,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [OUT_WIDTH-1:0]  out_sum,
  output logic                         out_overflow
);

  // Element count after lvl pairwise reductions: ceil(LENGTH / 2**lvl).
  function automatic int unsigned level_count(int unsigned lvl);
    return (LENGTH + (32'd1 << lvl) - 32'd1) >> lvl;
  endfunction

  logic                        advance;
  logic                        out_valid_q, out_valid_d;
  logic signed [OUT_WIDTH-1:0] out_sum_q, out_sum_d;
  logic                        out_ovf_q, out_ovf_d;
  logic signed [OUT_WIDTH-1:0] acc_q, acc_d;
  logic                        ovf_q, ovf_d;

  assign advance   = !out_valid_q || out_ready;
  assign in_ready  = advance;

  for (genvar k = 0; k < TREE_DEPTH; k++) begin : g_lvl
    localparam int unsigned WI = DATA_WIDTH + k;
    localparam int unsigned WO = WI + 1;
    localparam int unsigned NI = level_count(k);
    localparam int unsigned NO = level_count(k + 1);

    logic signed [WI-1:0] src [NI];
    logic                 src_vld, src_mode, src_last;
    logic signed [WO-1:0] sum_d  [NO];
    logic signed [WO-1:0] data_q [NO];
    logic                 vld_q, mode_q, last_q;

    if (k == 0) begin : g_src
      assign src      = in_addends;
      assign src_vld  = in_valid;
      assign src_mode = in_mode;
      assign src_last = in_last;
    end else begin : g_src
      assign src      = g_lvl[k-1].data_q;
      assign src_vld  = g_lvl[k-1].vld_q;
      assign src_mode = g_lvl[k-1].mode_q;
      assign src_last = g_lvl[k-1].last_q;
    end

    for (genvar i = 0; i < NO; i++) begin : g_pair
      if (2 * i + 1 < NI) begin : g_add
        assign sum_d[i] = WO'(src[2*i]) + WO'(src[2*i+1]);
      end else begin : g_pass
        assign sum_d[i] = WO'(src[2*i]);
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        vld_q  <= 1'b0;
        mode_q <= 1'b0;
        last_q <= 1'b0;
      end else if (advance) begin
        vld_q  <= src_vld;
        mode_q <= src_mode;
        last_q <= src_last;
      end
    end

    // Data only loads with a valid beat, so idle/X inputs never reach the sum.
    always_ff @(posedge clk) begin
      if (advance && src_vld) begin
        data_q <= sum_d;
      end
    end
  end

  logic signed [SUM_WIDTH-1:0] tree_sum;
  logic signed [OUT_WIDTH-1:0] tree_ext;
  logic signed [OUT_WIDTH-1:0] acc_sum;
  logic                        add_ovf;
  logic                        fin_vld, fin_mode, fin_last;

  assign tree_sum = g_lvl[TREE_DEPTH-1].data_q[0];
  assign fin_vld  = g_lvl[TREE_DEPTH-1].vld_q;
  assign fin_mode = g_lvl[TREE_DEPTH-1].mode_q;
  assign fin_last = g_lvl[TREE_DEPTH-1].last_q;
  assign tree_ext = OUT_WIDTH'(tree_sum);
  assign acc_sum  = acc_q + tree_ext;
  assign add_ovf  = (acc_q[OUT_WIDTH-1] == tree_ext[OUT_WIDTH-1]) &&
                    (acc_sum[OUT_WIDTH-1] != acc_q[OUT_WIDTH-1]);

  always_comb begin
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_ovf_d   = out_ovf_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    if (advance) begin
      out_valid_d = 1'b0;
      if (fin_vld) begin
        if (!fin_mode) begin
          out_valid_d = 1'b1;
          out_sum_d   = tree_ext;
          out_ovf_d   = 1'b0;
        end else if (fin_last) begin
          out_valid_d = 1'b1;
          out_sum_d   = acc_sum;
          out_ovf_d   = ovf_q | add_ovf;
          acc_d       = '0;
          ovf_d       = 1'b0;
        end else begin
          acc_d = acc_sum;
          ovf_d = ovf_q | add_ovf;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_ovf_q   <= out_ovf_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_sum      = out_sum_q;
  assign out_overflow = out_ovf_q;

endmodule

// File: tb/tb_adder_tree_accumulator.sv
// Bench for adder_tree_accumulator: default instance plus an ACC_EXTRA=0 instance on shared
// stimulus, checked against a plain-arithmetic packet model and hand-computed literals.
module tb_adder_tree_accumulator;
  localparam int DW  = 5;
  localparam int LEN = 9;
  localparam int WA  = 11;
  localparam int WB  = 9;

  typedef logic signed [DW-1:0] vec_t [LEN];
  typedef struct {
    longint sa;
    bit     oa;
    longint sb;
    bit     ob;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_mode = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b1;
  vec_t in_addends;
  logic in_ready_a, in_ready_b, out_valid_a, out_valid_b, ovf_a, ovf_b;
  logic signed [WA-1:0] sum_a;
  logic signed [WB-1:0] sum_b;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  adder_tree_accumulator #(.DATA_WIDTH(DW), .LENGTH(LEN), .ACC_EXTRA(2)) u_dut (
    .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_addends(in_addends), .in_mode(in_mode), .in_last(in_last),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_sum(sum_a), .out_overflow(ovf_a)
  );

  adder_tree_accumulator #(.DATA_WIDTH(DW), .LENGTH(LEN), .ACC_EXTRA(0)) u_dut_narrow (
    .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_addends(in_addends), .in_mode(in_mode), .in_last(in_last),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_sum(sum_b), .out_overflow(ovf_b)
  );

  task automatic check(input string name, input longint got, input longint want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic longint wrap(input longint v, input int w);
    longint m, r;
    m = longint'(1) << w;
    r = v % m;
    if (r < 0) r += m;
    if (r >= (m >> 1)) r -= m;
    return r;
  endfunction

  function automatic bit out_of_range(input longint v, input int w);
    return (v >= (longint'(1) << (w - 1))) || (v < -(longint'(1) << (w - 1)));
  endfunction

  // Packet-level model: beat sums in acceptance order, results popped at each handshake.
  exp_t   exp_q[$];
  longint acc_a, acc_b;
  bit     movf_a, movf_b;
  bit     stall;
  longint hold_a, hold_b;
  bit     hold_oa, hold_ob;

  initial begin
    exp_t   e;
    longint s, ta, tb;
    acc_a = 0; acc_b = 0; movf_a = 0; movf_b = 0; stall = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        acc_a = 0; acc_b = 0; movf_a = 0; movf_b = 0; stall = 0;
        check("reset in_ready", longint'(in_ready_a), 1);
        check("reset out_valid", longint'(out_valid_a | out_valid_b), 0);
        check("reset out_sum", longint'(sum_a), 0);
        check("reset out_overflow", longint'(ovf_a | ovf_b), 0);
      end else begin
        check("in_ready a", longint'(in_ready_a), longint'(!out_valid_a || out_ready));
        check("in_ready b", longint'(in_ready_b), longint'(!out_valid_b || out_ready));
        if (stall) begin
          check("hold out_valid", longint'(out_valid_a), 1);
          check("hold out_sum a", longint'(sum_a), hold_a);
          check("hold out_sum b", longint'(sum_b), hold_b);
          check("hold out_overflow", longint'({ovf_a, ovf_b}), longint'({hold_oa, hold_ob}));
        end
        if ((out_valid_a || out_valid_b) && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected output", longint'(out_valid_a | out_valid_b), 0);
          end else begin
            e = exp_q.pop_front();
            check("model out_valid a", longint'(out_valid_a), 1);
            check("model out_valid b", longint'(out_valid_b), 1);
            check("model out_sum a", longint'(sum_a), e.sa);
            check("model out_overflow a", longint'(ovf_a), longint'(e.oa));
            check("model out_sum b", longint'(sum_b), e.sb);
            check("model out_overflow b", longint'(ovf_b), longint'(e.ob));
          end
        end
        stall   = out_valid_a && !out_ready;
        hold_a  = longint'(sum_a);
        hold_b  = longint'(sum_b);
        hold_oa = ovf_a;
        hold_ob = ovf_b;
        if (in_valid && in_ready_a) begin
          s = 0;
          for (int i = 0; i < LEN; i++) s += longint'(in_addends[i]);
          if (!in_mode) begin
            e = '{wrap(s, WA), 1'b0, wrap(s, WB), 1'b0};
            exp_q.push_back(e);
          end else begin
            ta = acc_a + s;
            tb = acc_b + s;
            if (out_of_range(ta, WA)) movf_a = 1;
            if (out_of_range(tb, WB)) movf_b = 1;
            acc_a = wrap(ta, WA);
            acc_b = wrap(tb, WB);
            if (in_last) begin
              e = '{acc_a, movf_a, acc_b, movf_b};
              exp_q.push_back(e);
              acc_a = 0; acc_b = 0; movf_a = 0; movf_b = 0;
            end
          end
        end
      end
    end
  end

  vec_t xv;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input vec_t v, input logic mode, input logic last);
    int n;
    in_addends = v;
    in_mode    = mode;
    in_last    = last;
    in_valid   = 1'b1;
    n = 0;
    while (!in_ready_a && n < 50) begin
      tick();
      n++;
    end
    check("send accepted", longint'(in_ready_a), 1);
    tick();
    in_valid   = 1'b0;
    in_addends = xv;
  endtask

  task automatic wait_out(output longint ra, output bit oa, output longint rb, output bit ob);
    bit found;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (out_valid_a) found = 1;
    end
    check("wait_out result seen", longint'(found), 1);
    ra = longint'(sum_a);
    oa = ovf_a;
    rb = longint'(sum_b);
    ob = ovf_b;
  endtask

  function automatic vec_t fill(input int x);
    vec_t v;
    foreach (v[i]) v[i] = DW'(x);
    return v;
  endfunction

  initial begin
    vec_t   v1, ones, twos, f15, mneg;
    longint ra, rb;
    bit     oa, ob;
    foreach (xv[i]) xv[i] = 'x;
    v1   = '{1, -2, 3, -4, 5, -6, 7, -8, 9};
    ones = fill(1);
    twos = fill(2);
    f15  = fill(15);
    mneg = fill(-16);
    in_addends = xv;

    repeat (2) tick();
    check("in_ready during reset", longint'(in_ready_a), 1);
    rst_n = 1'b1;
    tick();
    check("in_ready after reset", longint'(in_ready_a), 1);
    check("out_valid after reset", longint'(out_valid_a), 0);

    // Mode-0 latency: result visible after the fifth edge counting the acceptance edge.
    send(v1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("latency early out_valid", longint'(out_valid_a), 0);
      tick();
    end
    check("latency out_valid", longint'(out_valid_a), 1);
    check("mode0 out_sum", longint'(sum_a), 5);
    check("mode0 out_overflow", longint'(ovf_a), 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("quiet after X inputs", longint'(out_valid_a), 0);
    end

    // Three-beat accumulate packet.
    send(v1, 1'b1, 1'b0);
    send(v1, 1'b1, 1'b0);
    send(v1, 1'b1, 1'b1);
    wait_out(ra, oa, rb, ob);
    check("acc3 out_sum", ra, 15);
    check("acc3 out_overflow", longint'(oa), 0);
    repeat (4) tick();

    // Backpressure: stall four cycles with the first result pending.
    out_ready = 1'b0;
    send(v1, 1'b0, 1'b0);
    send(mneg, 1'b0, 1'b0);
    send(twos, 1'b0, 1'b0);
    wait_out(ra, oa, rb, ob);
    for (int i = 0; i < 4; i++) begin
      check("stall in_ready", longint'(in_ready_a), 0);
      check("stall out_sum", longint'(sum_a), 5);
      tick();
    end
    out_ready = 1'b1;
    check("release first", longint'(sum_a), 5);
    tick();
    check("release second valid", longint'(out_valid_a), 1);
    check("release second", longint'(sum_a), -144);
    tick();
    check("release third", longint'(sum_a), 18);
    tick();
    check("release drained", longint'(out_valid_a), 0);
    repeat (4) tick();

    // Wrap in the narrow instance, then a fresh packet after the clear.
    send(f15, 1'b1, 1'b0);
    send(f15, 1'b1, 1'b1);
    wait_out(ra, oa, rb, ob);
    check("wide 270 out_sum", ra, 270);
    check("wide 270 out_overflow", longint'(oa), 0);
    check("narrow wrap out_sum", rb, -242);
    check("narrow wrap out_overflow", longint'(ob), 1);
    send(ones, 1'b1, 1'b1);
    wait_out(ra, oa, rb, ob);
    check("narrow after clear out_sum", rb, 9);
    check("narrow after clear out_overflow", longint'(ob), 0);
    repeat (4) tick();

    // Reset mid-packet with the beat still in flight.
    send(ones, 1'b1, 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
    check("mid reset out_valid", longint'(out_valid_a), 0);
    tick();
    rst_n = 1'b1;
    tick();
    send(twos, 1'b1, 1'b1);
    wait_out(ra, oa, rb, ob);
    check("post reset out_sum", ra, 18);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("post reset quiet", longint'(out_valid_a), 0);
    end

    // Mode-0 beat interleaved inside an open accumulate packet.
    send(ones, 1'b1, 1'b0);
    send(v1, 1'b0, 1'b0);
    send(ones, 1'b1, 1'b1);
    wait_out(ra, oa, rb, ob);
    check("interleave first", ra, 5);
    wait_out(ra, oa, rb, ob);
    check("interleave second", ra, 18);
    check("interleave overflow", longint'(oa), 0);

    repeat (10) tick();
    check("model queue drained", longint'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
